norm_sched: RTL

- Sequences and shares one 32-bit leading-zero-count/normalize datapath (lzc plus left barrel shift) between two FPU requesters: ch0 = add/sub unit, ch1 = mul/div unit.
- Round-robin arbitration, multi-cycle normalize sequence, exponent adjust with underflow/zero flags, valid/ready output toward the rounding stage.
- Single-occupancy: exactly one operation in flight at a time.

---
 rtl/norm_sched.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/norm_sched.sv
// -----------------------------------------------------------------------------
// norm_sched
//
// Shares one 32-bit leading-zero-count / left-normalize datapath between two
// FPU requesters (ch0 = add/sub, ch1 = mul/div). Round-robin arbitration picks
// one request at a time. Each operation runs IDLE -> COUNT -> SHIFT -> DONE and
// its result is held on a valid/ready interface toward the rounding stage.
// Only one operation is ever in flight.
//
// Parameters:
//   EXP_W  exponent width (unsigned, biased)
//   TAG_W  opaque requester tag width, returned unchanged
//
// Ports:
//   clk, rst_n                        clock (rising edge), async active-low reset
//   reqN_valid / reqN_ready           request handshake, N = 0,1 (ready is
//                                     combinational, only ever high in IDLE)
//   reqN_mant / reqN_exp / reqN_tag   unnormalized mantissa, exponent, tag
//   out_valid / out_ready             result handshake
//   out_mant                          normalized mantissa (bit31 set unless zero)
//   out_exp                           adjusted exponent (0 on zero/underflow)
//   out_zero / out_uflow              zero-mantissa / exponent-underflow flags
//   out_src / out_tag                 granted channel and its tag
//
// Build option:
//   NORM_SCHED_FASTPATH_EN  when defined, zero or already-normalized mantissas
//                           skip SHIFT and complete from COUNT (2-cycle latency).
// -----------------------------------------------------------------------------
module norm_sched #(
   parameter int EXP_W = 8,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [31:0]      req0_mant,
   input  logic [EXP_W-1:0] req0_exp,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [31:0]      req1_mant,
   input  logic [EXP_W-1:0] req1_exp,
   input  logic [TAG_W-1:0] req1_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_mant,
   output logic [EXP_W-1:0] out_exp,
   output logic             out_zero,
   output logic             out_uflow,
   output logic             out_src,
   output logic [TAG_W-1:0] out_tag
);

   typedef enum logic [1:0] {S_IDLE, S_COUNT, S_SHIFT, S_DONE} state_e;

   state_e           state_q, state_d;
   logic             rr_ptr_q, rr_ptr_d;
   logic             gnt0, gnt1;

   // Captured request
   logic [31:0]      mant_q;
   logic [EXP_W-1:0] exp_q;
   logic [TAG_W-1:0] tag_q;
   logic             src_q;

   // Registered LZC result
   logic [4:0]       cnt_q;
   logic             zero_q;

   logic [4:0]       lzc_cnt;
   logic             lzc_zero;
   logic [4:0]       nrm_cnt;
   logic             nrm_zero;
   logic [31:0]      res_mant;
   logic [EXP_W-1:0] res_exp;
   logic             res_zero, res_uflow;
   logic             load_out;

   // Output registers
   logic [31:0]      out_mant_q;
   logic [EXP_W-1:0] out_exp_q;
   logic             out_zero_q, out_uflow_q, out_src_q;
   logic [TAG_W-1:0] out_tag_q;

   // Leading-zero count of the captured mantissa; an all-zero input reports
   // count 0 and is flagged separately.
   always_comb begin
      lzc_cnt  = 5'd0;
      lzc_zero = (mant_q == 32'd0);
      for (int i = 0; i < 32; i++) begin
         if (mant_q[i]) lzc_cnt = 5'(31 - i);
      end
   end

`ifdef NORM_SCHED_FASTPATH_EN
   logic fast_hit;
   assign fast_hit = lzc_zero || mant_q[31];
   // In COUNT the live LZC result feeds the normalizer so that zero and
   // already-normalized operands can be finished one cycle early.
   assign nrm_cnt  = (state_q == S_COUNT) ? lzc_cnt  : cnt_q;
   assign nrm_zero = (state_q == S_COUNT) ? lzc_zero : zero_q;
`else
   assign nrm_cnt  = cnt_q;
   assign nrm_zero = zero_q;
`endif

   // Normalize and adjust the exponent; the count is zero-extended for the
   // compare/subtract and the shift zero-fills.
   always_comb begin
      res_mant  = 32'd0;
      res_exp   = '0;
      res_zero  = 1'b0;
      res_uflow = 1'b0;
      if (nrm_zero) begin
         res_zero = 1'b1;
      end else begin
         res_mant = mant_q << nrm_cnt;
         if (exp_q > EXP_W'(nrm_cnt)) res_exp = exp_q - EXP_W'(nrm_cnt);
         else                         res_uflow = 1'b1;
      end
   end

   // FSM: state register
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // FSM: next state
   // NOTE: every signal gets a default first so no path through the case can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         S_IDLE: begin
            if (gnt0 || gnt1) begin
               state_d  = S_COUNT;
               rr_ptr_d = gnt0;   // point at the channel that was not granted
            end
         end
         S_COUNT: begin
            state_d = S_SHIFT;
`ifdef NORM_SCHED_FASTPATH_EN
            if (fast_hit) state_d = S_DONE;
`endif
         end
         S_SHIFT: state_d = S_DONE;
         S_DONE:  if (out_ready) state_d = S_IDLE;
      endcase
   end

   // FSM: outputs. rst_n gating keeps both readies low while reset is held,
   // even if requesters are already presenting valid.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state_q == S_IDLE && rst_n) begin
         if (req0_valid && (!req1_valid || !rr_ptr_q)) gnt0 = 1'b1;
         else if (req1_valid)                          gnt1 = 1'b1;
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign out_valid  = (state_q == S_DONE);
   assign load_out   = (state_d == S_DONE) && (state_q != S_DONE);

   // Datapath registers
   // NOTE: datapath registers are reset as well, so every output reads 0 in
   // reset and nothing downstream ever sees X.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mant_q      <= 32'd0;
         exp_q       <= '0;
         tag_q       <= '0;
         src_q       <= 1'b0;
         cnt_q       <= 5'd0;
         zero_q      <= 1'b0;
         out_mant_q  <= 32'd0;
         out_exp_q   <= '0;
         out_zero_q  <= 1'b0;
         out_uflow_q <= 1'b0;
         out_src_q   <= 1'b0;
         out_tag_q   <= '0;
      end else begin
         if (gnt0) begin
            mant_q <= req0_mant;
            exp_q  <= req0_exp;
            tag_q  <= req0_tag;
            src_q  <= 1'b0;
         end else if (gnt1) begin
            mant_q <= req1_mant;
            exp_q  <= req1_exp;
            tag_q  <= req1_tag;
            src_q  <= 1'b1;
         end
         if (state_q == S_COUNT) begin
            cnt_q  <= lzc_cnt;
            zero_q <= lzc_zero;
         end
         // Result registers change only on entry to DONE.
         if (load_out) begin
            out_mant_q  <= res_mant;
            out_exp_q   <= res_exp;
            out_zero_q  <= res_zero;
            out_uflow_q <= res_uflow;
            out_src_q   <= src_q;
            out_tag_q   <= tag_q;
         end
      end
   end

   assign out_mant  = out_mant_q;
   assign out_exp   = out_exp_q;
   assign out_zero  = out_zero_q;
   assign out_uflow = out_uflow_q;
   assign out_src   = out_src_q;
   assign out_tag   = out_tag_q;

endmodule
